// File: rtl/controller_dpad_mapper_if.sv
// Pocket controller record/key types and the controller_dpad_mapper port bundle.
package pocket;

  typedef enum logic [3:0] {
    controller_none               = 4'd0,
    controller_pocket             = 4'd1,
    controller_docked_no_analogue = 4'd2,
    controller_docked_analogue    = 4'd3,
    controller_keyboard           = 4'd4,
    controller_mouse              = 4'd5
  } controller_type_t;

  // Button bits occupy [15:0]; dpad_up is bit 0, face_start is bit 15.
  typedef struct packed {
    controller_type_t controller_type;
    logic [11:0]      unused;
    logic             face_start;
    logic             face_select;
    logic             trig_r3;
    logic             trig_l3;
    logic             trig_r2;
    logic             trig_l2;
    logic             trig_r1;
    logic             trig_l1;
    logic             face_y;
    logic             face_x;
    logic             face_b;
    logic             face_a;
    logic             dpad_right;
    logic             dpad_left;
    logic             dpad_down;
    logic             dpad_up;
  } key_t;

  typedef struct packed {
    key_t       key;
    logic [7:0] lstick_x;
    logic [7:0] lstick_y;
    logic [7:0] rstick_x;
    logic [7:0] rstick_y;
    logic [7:0] ltrig;
    logic [7:0] rtrig;
  } controller_t;

endpackage

interface controller_dpad_mapper_if #(
  parameter int unsigned NUM_CONTROLLERS = 2
);
  import pocket::*;

  controller_t controllers [1:4];
  logic        frame_tick;
  logic [15:0] turbo_mask  [1:NUM_CONTROLLERS];
  key_t        keys        [1:NUM_CONTROLLERS];
  logic [15:0] key_pressed [1:NUM_CONTROLLERS];
  logic        exists      [1:NUM_CONTROLLERS];

  modport master (
    output controllers, frame_tick, turbo_mask,
    input  keys, key_pressed, exists
  );

  modport slave (
    input  controllers, frame_tick, turbo_mask,
    output keys, key_pressed, exists
  );

endinterface

// File: rtl/controller_dpad_mapper.sv
// Maps Pocket controller records to per-player key words: stick-to-D-pad with
// hysteresis, SOCD cleaning, frame-paced turbo, presence and P1 mirroring.
module controller_dpad_mapper
  import pocket::*;
#(
  parameter int unsigned NUM_CONTROLLERS = 2,
  parameter logic        MAP_JOYSTICK    = 1'b1,
  parameter logic [7:0]  THRESH_ON       = 8'd64,
  parameter logic [7:0]  THRESH_OFF      = 8'd48,
  parameter int unsigned TURBO_FRAMES    = 4,
  parameter logic        SOCD_NEUTRAL    = 1'b1,
  parameter logic        MIRROR_P1       = 1'b0
) (
  input logic                     clk,
  input logic                     reset_n,
  controller_dpad_mapper_if.slave bus
);

  localparam int unsigned FC_W = (TURBO_FRAMES > 1) ? $clog2(TURBO_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(TURBO_FRAMES - 1);

  localparam logic signed [8:0] ON_P  = $signed({1'b0, THRESH_ON});
  localparam logic signed [8:0] ON_M  = -ON_P;
  localparam logic signed [8:0] OFF_P = $signed({1'b0, THRESH_OFF});
  localparam logic signed [8:0] OFF_M = -OFF_P;

  // Button bit positions inside key_t[15:0].
  localparam int unsigned B_UP    = 0;
  localparam int unsigned B_DOWN  = 1;
  localparam int unsigned B_LEFT  = 2;
  localparam int unsigned B_RIGHT = 3;

  // Pre-mirroring word of every player; player 1's entry feeds mirrored slots.
  key_t own_word [1:NUM_CONTROLLERS];

  // Controllers beyond NUM_CONTROLLERS and stick/trigger fields not mapped here.
  logic unused_inputs;
  assign unused_inputs = ^{bus.controllers[1], bus.controllers[2],
                           bus.controllers[3], bus.controllers[4]};

  for (genvar g = 1; g <= NUM_CONTROLLERS; g++) begin : g_player
    controller_t       ctrl;
    logic              present;
    logic              analog;
    logic signed [8:0] dx;
    logic signed [8:0] dy;
    logic              r_q, l_q, u_q, d_q;
    logic              r_nx, l_nx, u_nx, d_nx;
    logic              ph_q, ph_nx;
    logic [FC_W-1:0]   fc_q, fc_nx;
    logic [15:0]       raw;
    logic [15:0]       merged;
    logic [15:0]       btn;
    key_t              word_nx;
    key_t              keys_q;
    logic [15:0]       pressed_q;
    logic              exists_q;

    assign ctrl    = bus.controllers[g];
    assign raw     = ctrl.key[15:0];
    assign present = (g == 1)
                  || (ctrl.key.controller_type == controller_docked_analogue)
                  || (ctrl.key.controller_type == controller_docked_no_analogue);
    assign analog  = MAP_JOYSTICK
                  && (ctrl.key.controller_type == controller_docked_analogue);
    assign dx      = $signed({1'b0, ctrl.lstick_x}) - 9'sd128;
    assign dy      = $signed({1'b0, ctrl.lstick_y}) - 9'sd128;

    // Stick latches: set past THRESH_ON, clear inside THRESH_OFF, hold between.
    always_comb begin
      r_nx = 1'b0;
      l_nx = 1'b0;
      u_nx = 1'b0;
      d_nx = 1'b0;
      if (analog) begin
        r_nx = r_q;
        l_nx = l_q;
        u_nx = u_q;
        d_nx = d_q;
        if (dx >= ON_P)       r_nx = 1'b1;
        else if (dx < OFF_P)  r_nx = 1'b0;
        if (dx <= ON_M)       l_nx = 1'b1;
        else if (dx > OFF_M)  l_nx = 1'b0;
        if (dy <= ON_M)       u_nx = 1'b1;
        else if (dy > OFF_M)  u_nx = 1'b0;
        if (dy >= ON_P)       d_nx = 1'b1;
        else if (dy < OFF_P)  d_nx = 1'b0;
      end
    end

    // Direction merge, SOCD cleaning and turbo gating of the button word.
    always_comb begin
      merged          = raw;
      merged[B_RIGHT] = raw[B_RIGHT] | r_nx;
      merged[B_LEFT]  = raw[B_LEFT]  | l_nx;
      merged[B_UP]    = raw[B_UP]    | u_nx;
      merged[B_DOWN]  = raw[B_DOWN]  | d_nx;
      if (SOCD_NEUTRAL && merged[B_LEFT] && merged[B_RIGHT]) begin
        merged[B_LEFT]  = 1'b0;
        merged[B_RIGHT] = 1'b0;
      end
      if (SOCD_NEUTRAL && merged[B_UP] && merged[B_DOWN]) begin
        merged[B_UP]   = 1'b0;
        merged[B_DOWN] = 1'b0;
      end

      ph_nx = ph_q;
      fc_nx = fc_q;
      if ((raw & bus.turbo_mask[g]) == '0) begin
        ph_nx = 1'b1;
        fc_nx = '0;
      end else if (bus.frame_tick) begin
        if (fc_q == FC_LAST) begin
          fc_nx = '0;
          ph_nx = ~ph_q;
        end else begin
          fc_nx = fc_q + 1'b1;
        end
      end

      // Gate on the updated phase so a frame tick shows on keys one cycle later.
      btn = merged & ~(bus.turbo_mask[g] & {16{~ph_nx}});
    end

    assign own_word[g] = present ? key_t'({ctrl.key[31:16], btn})
                                 : key_t'({ctrl.key[31:16], 16'h0000});

    // Absent players 2..N optionally take player 1's final word.
    always_comb begin
      word_nx = own_word[g];
      if ((g > 1) && !present && MIRROR_P1) word_nx = own_word[1];
    end

    // Output, stick latch and turbo state registers.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        keys_q    <= '0;
        pressed_q <= '0;
        exists_q  <= 1'b0;
        r_q       <= 1'b0;
        l_q       <= 1'b0;
        u_q       <= 1'b0;
        d_q       <= 1'b0;
        ph_q      <= 1'b1;
        fc_q      <= '0;
      end else begin
        keys_q    <= word_nx;
        pressed_q <= word_nx[15:0] & ~keys_q[15:0];
        exists_q  <= present;
        r_q       <= r_nx;
        l_q       <= l_nx;
        u_q       <= u_nx;
        d_q       <= d_nx;
        ph_q      <= ph_nx;
        fc_q      <= fc_nx;
      end
    end

    assign bus.keys[g]        = keys_q;
    assign bus.key_pressed[g] = pressed_q;
    assign bus.exists[g]      = exists_q;
  end

endmodule

// File: tb/tb_controller_dpad_mapper.sv
// Scoreboard bench for controller_dpad_mapper: dut_a (turbo 2 frames, mirror on,
// SOCD neutral) and dut_b (SOCD off, mirror off) share one stimulus stream.
module tb_controller_dpad_mapper;
  import pocket::*;

  localparam int TF_A = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  controller_t ctl   [1:4];
  logic        frame_tick;
  logic [15:0] tmask [1:2];

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    int          d;
    int          sel;
    int          p;
    logic [15:0] mask;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  controller_dpad_mapper_if #(.NUM_CONTROLLERS(2)) bus_a ();
  controller_dpad_mapper_if #(.NUM_CONTROLLERS(2)) bus_b ();

  assign bus_a.controllers = ctl;
  assign bus_a.frame_tick  = frame_tick;
  assign bus_a.turbo_mask  = tmask;
  assign bus_b.controllers = ctl;
  assign bus_b.frame_tick  = frame_tick;
  assign bus_b.turbo_mask  = tmask;

  controller_dpad_mapper #(
    .NUM_CONTROLLERS(2),
    .TURBO_FRAMES(TF_A),
    .SOCD_NEUTRAL(1'b1),
    .MIRROR_P1(1'b1)
  ) dut_a (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus_a)
  );

  controller_dpad_mapper #(
    .NUM_CONTROLLERS(2),
    .TURBO_FRAMES(4),
    .SOCD_NEUTRAL(1'b0),
    .MIRROR_P1(1'b0)
  ) dut_b (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus_b)
  );

  function automatic controller_t mk(controller_type_t t, logic [15:0] b,
                                     logic [7:0] x, logic [7:0] y);
    controller_t c;
    c          = '0;
    c.key      = key_t'({t, 12'h000, b});
    c.lstick_x = x;
    c.lstick_y = y;
    return c;
  endfunction

  // sel: 0 keys[15:0], 1 key_pressed, 2 exists, 3 keys[31:16]
  function automatic logic [15:0] obs(int d, int sel, int p);
    key_t        k;
    logic [15:0] kp;
    logic        ex;
    if (d == 0) begin
      k  = (p == 1) ? bus_a.keys[1]        : bus_a.keys[2];
      kp = (p == 1) ? bus_a.key_pressed[1] : bus_a.key_pressed[2];
      ex = (p == 1) ? bus_a.exists[1]      : bus_a.exists[2];
    end else begin
      k  = (p == 1) ? bus_b.keys[1]        : bus_b.keys[2];
      kp = (p == 1) ? bus_b.key_pressed[1] : bus_b.key_pressed[2];
      ex = (p == 1) ? bus_b.exists[1]      : bus_b.exists[2];
    end
    case (sel)
      0:       return k[15:0];
      1:       return kp;
      2:       return {15'b0, ex};
      default: return k[31:16];
    endcase
  endfunction

  task automatic push(string n, int d, int sel, int p, logic [15:0] m, logic [15:0] e);
    exp_t x;
    x = '{n, d, sel, p, m, e};
    sb.push_back(x);
  endtask

  task automatic test_reset();
    exp_t        e;
    logic [15:0] act;
    for (int c = 0; c < 3; c++) begin
      reset_n = (c == 2);
      for (int d = 0; d < 2; d++) begin
        push("rst_keys1", d, 0, 1, 16'hFFFF, 16'h0000);
        push("rst_press1", d, 1, 1, 16'hFFFF, 16'h0000);
        push("rst_exists1", d, 2, 1, 16'h0001, (c == 2) ? 16'h0001 : 16'h0000);
        push("rst_exists2", d, 2, 2, 16'h0001, 16'h0000);
      end
      @(posedge clk); #1;
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = obs(e.d, e.sel, e.p) & e.mask;
        total++;
        if (act !== (e.exp & e.mask)) begin
          bad++;
          $display("FAIL %s: got %h want %h", e.name, act, e.exp & e.mask);
        end
      end
    end
  endtask

  task automatic test_hysteresis();
    exp_t        e;
    logic [15:0] act;
    logic [7:0]  xs [5] = '{8'd128, 8'd192, 8'd180, 8'd175, 8'd128};
    logic        er [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        ep [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      ctl[1] = mk(controller_docked_analogue, 16'h0000, xs[i], 8'd128);
      push("hyst_keys", 0, 0, 1, 16'h000F, {12'h000, er[i], 3'b000});
      push("hyst_press", 0, 1, 1, 16'h000F, {12'h000, ep[i], 3'b000});
      @(posedge clk); #1;
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = obs(e.d, e.sel, e.p) & e.mask;
        total++;
        if (act !== (e.exp & e.mask)) begin
          bad++;
          $display("FAIL %s step%0d: got %h want %h", e.name, i, act, e.exp & e.mask);
        end
      end
    end
  endtask

  task automatic test_socd();
    exp_t        e;
    logic [15:0] act;
    for (int c = 0; c < 3; c++) begin
      if (c < 2) ctl[1] = mk(controller_docked_analogue, 16'h0004, 8'd255, 8'd128);
      else       ctl[1] = mk(controller_docked_analogue, 16'h0000, 8'd128, 8'd128);
      push("socd_neutral", 0, 0, 1, 16'h000C, 16'h0000);
      push("socd_off", 1, 0, 1, 16'h000C, (c < 2) ? 16'h000C : 16'h0000);
      @(posedge clk); #1;
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = obs(e.d, e.sel, e.p) & e.mask;
        total++;
        if (act !== (e.exp & e.mask)) begin
          bad++;
          $display("FAIL %s: got %h want %h", e.name, act, e.exp & e.mask);
        end
      end
    end
  endtask

  task automatic test_turbo();
    exp_t        e;
    logic [15:0] act;
    logic        on;
    logic        prev_on;
    logic [15:0] w;
    tmask[1] = 16'h0010;
    prev_on  = 1'b0;
    // cycle 0 is the fresh press; then a tick cycle and a quiet cycle per frame
    for (int s = 0; s <= 16; s++) begin
      int t;
      t          = (s + 1) / 2;
      frame_tick = (s % 2 == 1);
      ctl[1]     = mk(controller_docked_analogue, 16'h0030, 8'd128, 8'd128);
      on         = ((t / TF_A) % 2) == 0;
      w          = on ? 16'h0030 : 16'h0020;
      push("turbo_keys", 0, 0, 1, 16'h0030, w);
      push("turbo_press", 0, 1, 1, 16'h0030,
           {10'b0, (s == 0), (on && !prev_on), 4'b0});
      push("turbo_mirror", 0, 0, 2, 16'hFFFF, w);
      prev_on = on;
      @(posedge clk); #1;
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = obs(e.d, e.sel, e.p) & e.mask;
        total++;
        if (act !== (e.exp & e.mask)) begin
          bad++;
          $display("FAIL %s step%0d: got %h want %h", e.name, s, act, e.exp & e.mask);
        end
      end
    end
    frame_tick = 1'b0;
    ctl[1]     = mk(controller_docked_analogue, 16'h0000, 8'd128, 8'd128);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    exp_t        e;
    logic [15:0] act;
    logic [15:0] want [5] = '{16'h0018, 16'h0018, 16'h0008, 16'h0000, 16'h0018};
    tmask[1] = 16'h0010;
    ctl[1]   = mk(controller_docked_analogue, 16'h0010, 8'd255, 8'd128);
    for (int s = 0; s < 5; s++) begin
      frame_tick = (s == 1 || s == 2);
      reset_n    = (s != 3);
      push("rmid_keys", 0, 0, 1, 16'hFFFF, want[s]);
      if (s >= 3) begin
        push("rmid_press", 0, 1, 1, 16'hFFFF, want[s]);
        push("rmid_exists", 0, 2, 1, 16'h0001, (s == 4) ? 16'h0001 : 16'h0000);
      end
      @(posedge clk); #1;
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = obs(e.d, e.sel, e.p) & e.mask;
        total++;
        if (act !== (e.exp & e.mask)) begin
          bad++;
          $display("FAIL %s step%0d: got %h want %h", e.name, s, act, e.exp & e.mask);
        end
      end
    end
    frame_tick = 1'b0;
    reset_n    = 1'b1;
    tmask[1]   = 16'h0000;
    ctl[1]     = mk(controller_docked_analogue, 16'h0000, 8'd128, 8'd128);
    @(posedge clk); #1;
  endtask

  task automatic test_mirror();
    exp_t        e;
    logic [15:0] act;
    logic [15:0] p1b [5] = '{16'h0021, 16'h0101, 16'h0000, 16'h0021, 16'h0021};
    for (int s = 0; s < 5; s++) begin
      ctl[1] = mk(controller_docked_analogue, p1b[s], 8'd128, 8'd128);
      if (s < 3) begin
        ctl[2] = mk(controller_none, 16'h0080, 8'd255, 8'd128);
        push("mir_keys2", 0, 0, 2, 16'hFFFF, p1b[s]);
        push("mir_type2", 0, 3, 2, 16'hFFFF, 16'h3000);
        push("mir_exists2", 0, 2, 2, 16'h0001, 16'h0000);
        push("nomir_keys2", 1, 0, 2, 16'hFFFF, 16'h0000);
      end else begin
        ctl[2] = mk(controller_docked_no_analogue, 16'h0080, 8'd255, 8'd128);
        push("own_keys2", 0, 0, 2, 16'hFFFF, 16'h0080);
        push("own_type2", 0, 3, 2, 16'hFFFF, 16'h2000);
        push("own_exists2", 0, 2, 2, 16'h0001, 16'h0001);
        push("own_keys1", 0, 0, 1, 16'hFFFF, 16'h0021);
        push("own_exists2_b", 1, 2, 2, 16'h0001, 16'h0001);
        push("own_keys2_b", 1, 0, 2, 16'hFFFF, 16'h0080);
      end
      @(posedge clk); #1;
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = obs(e.d, e.sel, e.p) & e.mask;
        total++;
        if (act !== (e.exp & e.mask)) begin
          bad++;
          $display("FAIL %s step%0d: got %h want %h", e.name, s, act, e.exp & e.mask);
        end
      end
    end
    ctl[2] = mk(controller_none, 16'h0000, 8'd128, 8'd128);
    ctl[1] = mk(controller_docked_analogue, 16'h0000, 8'd128, 8'd128);
    @(posedge clk); #1;
  endtask

  task automatic test_non_analogue();
    exp_t        e;
    logic [15:0] act;
    logic [15:0] b [3] = '{16'h0000, 16'h0008, 16'h0000};
    for (int s = 0; s < 3; s++) begin
      ctl[1] = mk(controller_pocket, b[s], 8'd255, 8'd0);
      push("pocket_keys", 0, 0, 1, 16'hFFFF, b[s]);
      push("pocket_press", 0, 1, 1, 16'hFFFF, (s == 1) ? 16'h0008 : 16'h0000);
      push("pocket_exists", 0, 2, 1, 16'h0001, 16'h0001);
      @(posedge clk); #1;
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = obs(e.d, e.sel, e.p) & e.mask;
        total++;
        if (act !== (e.exp & e.mask)) begin
          bad++;
          $display("FAIL %s step%0d: got %h want %h", e.name, s, act, e.exp & e.mask);
        end
      end
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    frame_tick = 1'b0;
    tmask[1]   = 16'h0000;
    tmask[2]   = 16'h0000;
    ctl[1]     = mk(controller_docked_analogue, 16'h0000, 8'd128, 8'd128);
    ctl[2]     = mk(controller_none, 16'h0000, 8'd128, 8'd128);
    ctl[3]     = '0;
    ctl[4]     = '0;
    #2;
    test_reset();
    test_hysteresis();
    test_socd();
    test_turbo();
    test_reset_mid();
    test_mirror();
    test_non_analogue();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/controller_dpad_mapper.md
# controller_dpad_mapper

Registered, parametrised controller front end that turns up to four Pocket controller records into per-player `pocket::key_t` D-pad/button words. It does three things:

- Converts the left analogue stick into D-pad directions with programmable threshold and hysteresis.
- Applies optional per-button turbo paced by a frame strobe, plus optional SOCD cleaning.
- Flags players whose controller is absent and can mirror player 1 into them.

It sits between `controller_connect` outputs and core input logic.

## Interface

- `NUM_CONTROLLERS`, 2: players produced, 1..4.
- `MAP_JOYSTICK`, 1'b1: enable stick-to-D-pad mapping.
- `THRESH_ON`, 8'd64: stick deviation from centre (128) that asserts a direction, 1..127.
- `THRESH_OFF`, 8'd48: deviation below which an asserted direction releases; must be ≤ `THRESH_ON`.
- `TURBO_FRAMES`, 4: frames per turbo half-period, ≥1.
- `SOCD_NEUTRAL`, 1'b1: opposing directions both asserted resolve to neither.
- `MIRROR_P1`, 1'b0: absent players 2..N output player 1's keys.

Ports:

- `clk`  in  1  sole clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `controllers`  in  controller_t [1:4]  raw controller records.
- `frame_tick`  in  1  one-cycle pulse per video frame.
- `turbo_mask`  in  16 × [1:NUM_CONTROLLERS]  per-player turbo enable, per button bit `key[15:0]`.
- `keys`  out  pocket::key_t × [1:NUM_CONTROLLERS]  mapped key words.
- `key_pressed`  out  16 × [1:NUM_CONTROLLERS]  one-cycle rising-edge pulses of `keys[i][15:0]`.
- `exists`  out  1 × [1:NUM_CONTROLLERS]  player has a controller.

## Operation

- **Presence.** `exists[i]` is 1 for `i==1` unconditionally. For `i>1` it is 1 when `controllers[i].key.controller_type` is `controller_docked_analogue` or `controller_docked_no_analogue`.
- **Stick state.** Each player holds four latched bits R, L, U, D. They update only when `MAP_JOYSTICK` is set and the type is `controller_docked_analogue`; otherwise all four are held at 0.
  - Deviation is 9-bit signed: dx = lstick_x − 128, dy = lstick_y − 128.
  - R sets when dx ≥ THRESH_ON and clears when dx < THRESH_OFF.
  - L sets when dx ≤ −THRESH_ON and clears when dx > −THRESH_OFF.
  - U uses dy ≤ −THRESH_ON / dy > −THRESH_OFF.
  - D uses dy ≥ THRESH_ON / dy < THRESH_OFF.
  - Between the two thresholds a bit holds its state.
- **Direction merge.** Each direction = digital D-pad bit OR latched stick bit. If `SOCD_NEUTRAL` is set, left&right both asserted → both 0, and up&down both asserted → both 0.
- **Turbo.** Each player has a phase bit `ph` and a frame counter `fc`.
  - While `(raw buttons & turbo_mask[i]) == 0`: `ph=1` and `fc=0`.
  - Otherwise, on each `frame_tick`, `fc` increments. When `fc` reaches `TURBO_FRAMES−1` it wraps to 0 and `ph` toggles.
  - A masked button's output = raw & `ph`. Unmasked buttons pass through unchanged.
  - A fresh press is therefore always "on" for `TURBO_FRAMES` frames first.
- **Mirroring.** If `MIRROR_P1` is set and `exists[i]==0` for `i>1`, `keys[i]` = the final word of player 1; `exists[i]` stays 0. Otherwise an absent player outputs all-zero button bits.
- **Pass-through.** `controller_type` and all non-button fields of `key_t` pass through from controller i.
- **Edge detect.** `key_pressed[i] = next_keys[i][15:0] & ~keys[i][15:0]`.

## Timing

- `keys`, `key_pressed` and `exists` are registered. Latency from `controllers`/`frame_tick` to outputs is 1 cycle.
- A stick latch updates in the same edge as the output it affects, so a threshold crossing at cycle n appears on `keys` at n+1.
- A `key_pressed` bit is high for exactly the first cycle the matching `keys` bit is high. Each turbo re-assertion produces a new pulse.
- `frame_tick` held high for k consecutive cycles counts as k ticks.
- **Reset.** With `reset_n` low at a clock edge:
  - `keys`, `key_pressed` and `exists` go to 0.
  - Stick latches go to 0.
  - `ph=1`, `fc=0`.
  - This applies mid-turbo and mid-hysteresis alike. The first output after release reflects inputs sampled at the release edge.
- `controllers[NUM_CONTROLLERS+1..4]` are ignored, except that `controllers[1]` is always used.

## Test plan

- **Stick hysteresis.** Docked analogue, lstick_x sweeps 128→192→180→175→128. `dpad_right` rises at 192, holds at 180 (dx=52 ≥48), falls at 175 (dx=47). `key_pressed` pulses once, one cycle after x=192.
- **SOCD cleaning.** Digital left + stick right (x=255), `SOCD_NEUTRAL=1` → left=right=0. Repeat with `SOCD_NEUTRAL=0` → both 1.
- **Turbo.** `TURBO_FRAMES=2`, `turbo_mask=face_a`, hold A across 8 frame ticks → A pattern on,on,off,off,on,on,off,off. Unmasked B held stays 1. `key_pressed` pulses at each on-transition.
- **Presence and mirroring.** Controller 2 type none, `MIRROR_P1=1`: `exists[2]=0` and `keys[2]==keys[1]` every cycle. Change type to `controller_docked_no_analogue` → `exists[2]=1` one cycle later, with player 2's own keys and the stick ignored.
- **Reset mid-operation.** Assert `reset_n=0` for one cycle while turbo is off-phase and R is latched. Next outputs are all 0. After release with A still held, A=1 immediately (`ph` restarts on).
- **Non-analogue controller.** Pocket built-in controller with x=255 → `dpad_right` follows the digital bit only.
